// File: rtl/asic_iopoc_seq.sv
// Padring power-on sequencer: drives the control ring to the POC cell, stepping IO cells
// through isolation, bias, receiver and driver enables and tearing them down on supply loss.
module asic_iopoc_seq #(
    parameter int unsigned NCTRL = 8,
    parameter int unsigned DELAY = 16,
    parameter int unsigned CW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             vddio_ok,
    input  logic             vdd_ok,
    output logic [NCTRL-1:0] ctrlring,
    output logic             ready,
    output logic             fault,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_WAIT = 3'd1,
        S_BIAS = 3'd2,
        S_RCV  = 3'd3,
        S_DRV  = 3'd4,
        S_ON   = 3'd5,
        S_DOWN = 3'd6,
        S_ILL  = 3'd7
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_fault;
    logic          w_fault_nxt;
    logic          r_vddio_s1;
    logic          r_vddio_s2;
    logic          r_vdd_s1;
    logic          r_vdd_s2;
    logic          w_supply_ok;
    logic          w_step_done;

    // Two-flop synchronizers for the asynchronous supply-good flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vddio_s1 <= 1'b0;
            r_vddio_s2 <= 1'b0;
            r_vdd_s1   <= 1'b0;
            r_vdd_s2   <= 1'b0;
        end else begin
            r_vddio_s1 <= vddio_ok;
            r_vddio_s2 <= r_vddio_s1;
            r_vdd_s1   <= vdd_ok;
            r_vdd_s2   <= r_vdd_s1;
        end
    end

    assign w_supply_ok = r_vddio_s2 & r_vdd_s2;
    assign w_step_done = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fault_nxt = r_fault;
        unique case (r_state)
            S_OFF: begin
                if (!en) w_fault_nxt = 1'b0;
                else     w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!en)                             w_state_nxt = S_OFF;
                else if (w_supply_ok && w_step_done) w_state_nxt = S_BIAS;
            end
            S_BIAS, S_RCV, S_DRV, S_ON: begin
                // Teardown outranks step completion; fault records supply loss only
                if (!w_supply_ok || !en) begin
                    w_state_nxt = S_DOWN;
                    if (!w_supply_ok) w_fault_nxt = 1'b1;
                end else if (w_step_done) begin
                    if (r_state == S_BIAS)     w_state_nxt = S_RCV;
                    else if (r_state == S_RCV) w_state_nxt = S_DRV;
                    else if (r_state == S_DRV) w_state_nxt = S_ON;
                end
            end
            S_DOWN: begin
                if (w_step_done) w_state_nxt = en ? S_WAIT : S_OFF;
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    always_comb begin
        w_cnt_nxt = '0;
        if (w_state_nxt == r_state) begin
            unique case (r_state)
                S_WAIT:                       w_cnt_nxt = w_supply_ok ? r_cnt + 1'b1 : '0;
                S_BIAS, S_RCV, S_DRV, S_DOWN: w_cnt_nxt = r_cnt + 1'b1;
                default:                      w_cnt_nxt = '0;
            endcase
        end
    end

    // Moore decode of the ring: {poc_ok, drv_en, rcv_en, bias_en, iso}
    always_comb begin
        ctrlring = '0;
        unique case (r_state)
            S_BIAS:  ctrlring[4:0] = 5'b00011;
            S_RCV:   ctrlring[4:0] = 5'b00111;
            S_DRV:   ctrlring[4:0] = 5'b01111;
            S_ON:    ctrlring[4:0] = 5'b11110;
            S_DOWN:  ctrlring[4:0] = 5'b00011;
            default: ctrlring[4:0] = 5'b00001;
        endcase
    end

    assign ready = (r_state == S_ON);
    assign fault = r_fault;
    assign state = r_state;

endmodule

// File: tb/tb_asic_iopoc_seq.sv
// Directed bench for the padring power-on sequencer: one DUT at DELAY=4, one at DELAY=1/NCTRL=10.
module tb_asic_iopoc_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       vddio_ok = 1'b1;
    logic       vdd_ok = 1'b1;
    logic [7:0] ctrlring;
    logic       ready;
    logic       fault;
    logic [2:0] state;

    logic       en2 = 1'b0;
    logic       vddio_ok2 = 1'b1;
    logic       vdd_ok2 = 1'b1;
    logic [9:0] ctrlring2;
    logic       ready2;
    logic       fault2;
    logic [2:0] state2;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] OFF = 3'd0, WAIT = 3'd1, BIAS = 3'd2, RCV = 3'd3,
                           DRV = 3'd4, ON = 3'd5, DOWN = 3'd6;

    asic_iopoc_seq #(.NCTRL(8), .DELAY(4), .CW(4)) dut (
        .clk(clk), .reset(reset), .en(en), .vddio_ok(vddio_ok), .vdd_ok(vdd_ok),
        .ctrlring(ctrlring), .ready(ready), .fault(fault), .state(state)
    );

    asic_iopoc_seq #(.NCTRL(10), .DELAY(1), .CW(2)) dut2 (
        .clk(clk), .reset(reset), .en(en2), .vddio_ok(vddio_ok2), .vdd_ok(vdd_ok2),
        .ctrlring(ctrlring2), .ready(ready2), .fault(fault2), .state(state2)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Expected state i cycles after en was driven high with steady supplies
    function automatic logic [2:0] seq_state(input int i, input int d);
        if (i <= d)          return WAIT;
        else if (i <= 2 * d) return BIAS;
        else if (i <= 3 * d) return RCV;
        else if (i <= 4 * d) return DRV;
        else                 return ON;
    endfunction

    function automatic logic [9:0] ring_of(input logic [2:0] s);
        case (s)
            BIAS:    return 10'h003;
            RCV:     return 10'h007;
            DRV:     return 10'h00F;
            ON:      return 10'h01E;
            DOWN:    return 10'h003;
            default: return 10'h001;
        endcase
    endfunction

    task automatic test_reset;
        en = 1'b0; en2 = 1'b0;
        vddio_ok = 1'b1; vdd_ok = 1'b1; vddio_ok2 = 1'b1; vdd_ok2 = 1'b1;
        do_reset();
        n_tests++;
        if (state !== OFF) begin n_fail++; $display("FAIL reset_state got %0d want %0d", state, OFF); end
        n_tests++;
        if (ctrlring !== 8'h01) begin n_fail++; $display("FAIL reset_ring got %h want 01", ctrlring); end
        n_tests++;
        if (ready !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got ready=%b fault=%b want 0 0", ready, fault);
        end
        n_tests++;
        if (state2 !== OFF || ctrlring2 !== 10'h001) begin
            n_fail++; $display("FAIL reset_dut2 got state=%0d ring=%h want 0 001", state2, ctrlring2);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (state !== OFF) begin n_fail++; $display("FAIL idle_off got %0d want %0d", state, OFF); end
        end
    endtask

    task automatic test_power_up;
        logic [2:0] es;
        do_reset();
        repeat (9) tick();
        n_tests++;
        if (state !== OFF || ctrlring !== 8'h01) begin
            n_fail++; $display("FAIL pre_en got state=%0d ring=%h want 0 01", state, ctrlring);
        end
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            es = seq_state(i, 4);
            n_tests++;
            if (state !== es) begin n_fail++; $display("FAIL pwrup_state cyc%0d got %0d want %0d", i, state, es); end
            n_tests++;
            if (ctrlring !== ring_of(es)[7:0]) begin
                n_fail++; $display("FAIL pwrup_ring cyc%0d got %h want %h", i, ctrlring, ring_of(es)[7:0]);
            end
            n_tests++;
            if (ready !== (es == ON)) begin n_fail++; $display("FAIL pwrup_ready cyc%0d got %b want %b", i, ready, es == ON); end
        end
    endtask

    // Entered in ON with en=1; one-cycle vddio_ok drop, resequence back to ON with fault held
    task automatic drop_and_resequence(input int stop_at, input string tag);
        logic [2:0] es;
        vddio_ok = 1'b0;
        tick();
        vddio_ok = 1'b1;
        tick();
        n_tests++;
        if (state !== ON) begin n_fail++; $display("FAIL %s_sense_lat got %0d want %0d", tag, state, ON); end
        tick();
        n_tests++;
        if (state !== DOWN || ctrlring !== 8'h03 || fault !== 1'b1) begin
            n_fail++; $display("FAIL %s_down got state=%0d ring=%h fault=%b want 6 03 1", tag, state, ctrlring, fault);
        end
        for (int i = 1; i <= stop_at; i++) begin
            tick();
            es = (i <= 3) ? DOWN : seq_state(i - 3, 4);
            n_tests++;
            if (state !== es || fault !== 1'b1) begin
                n_fail++; $display("FAIL %s_reseq cyc%0d got state=%0d fault=%b want %0d 1", tag, i, state, fault, es);
            end
        end
    endtask

    task automatic test_supply_drop;
        drop_and_resequence(22, "drop");
        n_tests++;
        if (ctrlring !== 8'h1E || ready !== 1'b1) begin
            n_fail++; $display("FAIL drop_on got ring=%h ready=%b want 1e 1", ctrlring, ready);
        end
    endtask

    task automatic test_reset_mid_sequence;
        drop_and_resequence(16, "mid");
        n_tests++;
        if (state !== DRV) begin n_fail++; $display("FAIL mid_in_drv got %0d want %0d", state, DRV); end
        reset = 1'b1;
        en = 1'b0;
        tick();
        reset = 1'b0;
        n_tests++;
        if (state !== OFF || ctrlring !== 8'h01 || ready !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got state=%0d ring=%h ready=%b fault=%b want 0 01 0 0",
                               state, ctrlring, ready, fault);
        end
    endtask

    task automatic test_disable_in_rcv;
        do_reset();
        repeat (3) tick();
        en = 1'b1;
        repeat (9) tick();
        n_tests++;
        if (state !== RCV) begin n_fail++; $display("FAIL dis_in_rcv got %0d want %0d", state, RCV); end
        en = 1'b0;
        tick();
        n_tests++;
        if (state !== DOWN || ctrlring !== 8'h03 || fault !== 1'b0) begin
            n_fail++; $display("FAIL dis_down got state=%0d ring=%h fault=%b want 6 03 0", state, ctrlring, fault);
        end
        repeat (3) tick();
        n_tests++;
        if (state !== DOWN) begin n_fail++; $display("FAIL dis_hold got %0d want %0d", state, DOWN); end
        tick();
        n_tests++;
        if (state !== OFF || ctrlring !== 8'h01 || fault !== 1'b0) begin
            n_fail++; $display("FAIL dis_off got state=%0d ring=%h fault=%b want 0 01 0", state, ctrlring, fault);
        end
    endtask

    task automatic test_glitchy_wait;
        do_reset();
        vddio_ok = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        vddio_ok = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            tick();
            if (i % 3 == 0) vddio_ok = ~vddio_ok;
            n_tests++;
            if (state !== WAIT || ctrlring !== 8'h01 || ready !== 1'b0) begin
                n_fail++; $display("FAIL glitch cyc%0d got state=%0d ring=%h want 1 01", i, state, ctrlring);
            end
        end
        vddio_ok = 1'b1;
        en = 1'b0;
    endtask

    task automatic test_delay1;
        logic [2:0] es;
        en = 1'b0;
        do_reset();
        repeat (3) tick();
        en2 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            es = seq_state(i, 1);
            n_tests++;
            if (state2 !== es || ctrlring2 !== ring_of(es)) begin
                n_fail++; $display("FAIL d1_seq cyc%0d got state=%0d ring=%h want %0d %h", i, state2, ctrlring2, es, ring_of(es));
            end
        end
        n_tests++;
        if (ready2 !== 1'b1) begin n_fail++; $display("FAIL d1_ready got %b want 1", ready2); end
        vdd_ok2 = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (state2 !== ON) begin n_fail++; $display("FAIL d1_lat got %0d want %0d", state2, ON); end
        tick();
        n_tests++;
        if (state2 !== DOWN || ctrlring2 !== 10'h003 || fault2 !== 1'b1) begin
            n_fail++; $display("FAIL d1_down got state=%0d ring=%h fault=%b want 6 003 1", state2, ctrlring2, fault2);
        end
        tick();
        n_tests++;
        if (state2 !== WAIT || fault2 !== 1'b1) begin
            n_fail++; $display("FAIL d1_wait got state=%0d fault=%b want 1 1", state2, fault2);
        end
        en2 = 1'b0;
        tick();
        n_tests++;
        if (state2 !== OFF || fault2 !== 1'b1 || ctrlring2 !== 10'h001) begin
            n_fail++; $display("FAIL d1_off got state=%0d fault=%b ring=%h want 0 1 001", state2, fault2, ctrlring2);
        end
        tick();
        n_tests++;
        if (fault2 !== 1'b0 || ctrlring2 !== 10'h001) begin
            n_fail++; $display("FAIL d1_fault_clr got fault=%b ring=%h want 0 001", fault2, ctrlring2);
        end
        vdd_ok2 = 1'b1;
    endtask

    initial begin
        #2;
        test_reset();
        test_power_up();
        test_supply_drop();
        test_reset_mid_sequence();
        test_disable_in_rcv();
        test_glitchy_wait();
        test_delay1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
